f1_random_delay: RTL and testbench
==================================

Name: f1_random_delay

Overview:
- Random hold-off timer that sits beside the start-light sequencer in the F1 starting-light controller.
- Consumes the sequencer's start_delay and en_lfsr outputs and returns time_out, which ends the all-lights-on hold and extinguishes the lights.
- Contains a 16-bit LFSR that supplies the random component, plus a millisecond down-counter driven by the shared tick_ms pulse.

Parameters:
- SEED, 16'hACE1, LFSR reset and recovery value; must be non-zero.
- MIN_MS, 250, fixed minimum hold in ms; must be at least 1.
- RAND_BITS, 12, number of LFSR LSBs added to MIN_MS; range 1..16.
- DW, 17, counter and delay width; must hold MIN_MS + 2^RAND_BITS - 1.

Ports:
- sysclk, in, 1, system clock; all state updates on posedge.
- rst_n, in, 1, reset; asynchronous, active-low.
- tick_ms, in, 1, one-sysclk pulse per millisecond.
- en_lfsr, in, 1, LFSR advances each sysclk while 1.
- start_delay, in, 1, level input; 1 = arm/reload, falling to 0 starts the countdown.
- time_out, out, 1, registered; 1 once the hold has expired.
- busy, out, 1, registered; 1 while in COUNT.
- delay_ms, out, DW, registered; value captured for the current or last hold.
- lfsr_q, out, 16, current LFSR state (debug).

Behaviour:
- Reset values (async, rst_n=0): state=ARM, lfsr_q=SEED, count=0, delay_ms=0, time_out=0, busy=0.
- LFSR: Fibonacci, shift left, new bit0 = b15^b13^b12^b10 (x^16+x^14+x^13+x^11+1), period 65535.
  - Advances only when en_lfsr=1; holds otherwise.
  - If lfsr_q is ever 0, it reloads SEED next cycle regardless of en_lfsr.
- Candidate delay: cand = MIN_MS + (lfsr_q & (2^RAND_BITS-1)), zero-extended to DW. Default range is 250..4345 ms.
- State ARM:
  - Every cycle: count<=cand, delay_ms<=cand, time_out<=0, busy<=0. The value captured is cand on the last cycle start_delay=1.
  - start_delay=0 -> COUNT, busy<=1, no decrement in this transition cycle.
- State COUNT:
  - start_delay=1 has priority -> ARM and reloads next cycle; the current hold is abandoned and time_out stays 0.
  - Else on tick_ms=1 with count=1: count<=0, time_out<=1, busy<=0, -> DONE.
  - Else on tick_ms=1: count<=count-1.
  - tick_ms=0: hold.
- State DONE:
  - time_out stays 1 while start_delay=0.
  - start_delay=1 -> ARM with time_out<=0 in the same edge; reload begins the following cycle.
- Latency: time_out rises on the sysclk edge that samples the delay_ms-th tick_ms seen in COUNT. Ticks coincident with the ARM->COUNT transition are not counted.
- tick_ms and start_delay are sampled only on posedge; there is no edge detection. A start_delay held at 1 keeps the block in ARM indefinitely.
- Reset mid-operation: immediate return to reset values; a countdown in progress is lost.
- default/illegal state encoding -> ARM.

Test Plan:
- Reset and hold: rst_n=0 -> lfsr_q=16'hACE1, time_out=0, busy=0, delay_ms=0. Release rst_n with start_delay=1, en_lfsr=0 -> delay_ms=250+16'hCE1=3547 one cycle later.
- LFSR step: from SEED, pulse en_lfsr=1 for one cycle -> lfsr_q=16'h59C3. With start_delay=1, delay_ms=250+16'h9C3=2749. Run 65535 enabled cycles -> lfsr_q returns to 16'h59C3, never 0.
- Full countdown (MIN_MS=3, RAND_BITS=1, en_lfsr=0, SEED=16'hACE1 so LSB=1 -> delay 4):
  - Drop start_delay, apply 4 tick_ms pulses -> time_out=1 on the edge sampling the 4th pulse, busy 1->0, count=0.
  - time_out remains 1 through 10 further ticks.
- Tick on transition: same config, tick_ms=1 in the ARM->COUNT cycle -> that tick is ignored; time_out needs 4 more ticks.
- Abort/restart: in COUNT with count=2, raise start_delay -> next edge ARM, time_out stays 0, delay_ms reloaded. Drop start_delay -> full 4-tick countdown required again.
- Async reset mid-count: assert rst_n=0 between clock edges while busy=1 -> time_out=0, busy=0, lfsr_q=SEED immediately, without waiting for sysclk.

Source files
------------

// File: rtl/f1_random_delay.sv
// Random hold-off timer for the F1 start-light controller: a 16-bit LFSR picks the hold length,
// a millisecond down-counter times it and raises time_out when it expires.
module f1_random_delay #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned MIN_MS    = 250,
    parameter int unsigned RAND_BITS = 12,
    parameter int unsigned DW        = 17
) (
    input  logic          sysclk,
    input  logic          rst_n,
    input  logic          tick_ms,
    input  logic          en_lfsr,
    input  logic          start_delay,
    output logic          time_out,
    output logic          busy,
    output logic [DW-1:0] delay_ms,
    output logic [15:0]   lfsr_q
);

    typedef enum logic [1:0] {StArm, StCount, StDone} state_e;

    localparam logic [15:0] RandMask = 16'((32'd1 << RAND_BITS) - 32'd1);

    state_e        state_q, state_d;
    logic [DW-1:0] count_q, count_d;
    logic [DW-1:0] delay_d;
    logic          time_out_d, busy_d;
    logic [15:0]   lfsr_d;
    logic          feedback;
    logic [DW-1:0] cand;

    // x^16 + x^14 + x^13 + x^11 + 1; an all-zero state is a lock-up, so recover to SEED
    assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_comb begin
        lfsr_d = lfsr_q;
        if (lfsr_q == 16'h0000) begin
            lfsr_d = SEED;
        end else if (en_lfsr) begin
            lfsr_d = {lfsr_q[14:0], feedback};
        end
    end

    assign cand = DW'(MIN_MS) + DW'(lfsr_q & RandMask);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        delay_d    = delay_ms;
        time_out_d = time_out;
        busy_d     = busy;
        case (state_q)
            StArm: begin
                // Reload every cycle so the counter is never left at zero on entry to StCount
                count_d    = cand;
                delay_d    = cand;
                time_out_d = 1'b0;
                busy_d     = 1'b0;
                if (!start_delay) begin
                    state_d = StCount;
                    busy_d  = 1'b1;
                end
            end
            StCount: begin
                if (start_delay) begin
                    state_d    = StArm;
                    time_out_d = 1'b0;
                    busy_d     = 1'b0;
                end else if (tick_ms) begin
                    if (count_q == DW'(1)) begin
                        count_d    = '0;
                        time_out_d = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = StDone;
                    end else begin
                        count_d = count_q - DW'(1);
                    end
                end
            end
            StDone: begin
                if (start_delay) begin
                    state_d    = StArm;
                    time_out_d = 1'b0;
                end
            end
            default: begin
                state_d    = StArm;
                time_out_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StArm;
            lfsr_q   <= SEED;
            count_q  <= '0;
            delay_ms <= '0;
            time_out <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            count_q  <= count_d;
            delay_ms <= delay_d;
            time_out <= time_out_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_f1_random_delay.sv
// Bench for f1_random_delay: two instances (default and short-hold configs) checked every cycle
// against a tick-counting reference model, plus literal expectations from hand calculation.
module tb_f1_random_delay;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic [1:0]  sd, tk, en;
    logic [1:0]  to_w, busy_w;
    logic [16:0] dly_w [2];
    logic [15:0] lfsr_w [2];

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit saw_zero;

    always #5 sysclk = ~sysclk;

    f1_random_delay #(
        .SEED(SEED), .MIN_MS(250), .RAND_BITS(12), .DW(17)
    ) dut_a (
        .sysclk(sysclk), .rst_n(rst_n), .tick_ms(tk[0]), .en_lfsr(en[0]),
        .start_delay(sd[0]), .time_out(to_w[0]), .busy(busy_w[0]),
        .delay_ms(dly_w[0]), .lfsr_q(lfsr_w[0])
    );

    f1_random_delay #(
        .SEED(SEED), .MIN_MS(3), .RAND_BITS(1), .DW(17)
    ) dut_b (
        .sysclk(sysclk), .rst_n(rst_n), .tick_ms(tk[1]), .en_lfsr(en[1]),
        .start_delay(sd[1]), .time_out(to_w[1]), .busy(busy_w[1]),
        .delay_ms(dly_w[1]), .lfsr_q(lfsr_w[1])
    );

    task automatic check(input string name, input int inst, input longint act,
                         input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d] got %0d (0x%0h) want %0d (0x%0h) at %0t",
                     name, inst, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: phase 0 = waiting to arm, 1 = timing, 2 = expired.
    // Timing is tracked as ticks seen versus the captured delay.
    logic [15:0] m_lfsr [2];
    int          m_phase [2];
    int          m_delay [2];
    int          m_ticks [2];

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic fb;
        fb = ^(x & 16'hB400);
        return 16'((x << 1) | 16'(fb));
    endfunction

    function automatic int cand_of(input int inst, input logic [15:0] x);
        if (inst == 0) return 250 + int'(x & 16'h0FFF);
        return 3 + int'(x & 16'h0001);
    endfunction

    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_lfsr[i]  <= SEED;
                m_phase[i] <= 0;
                m_delay[i] <= 0;
                m_ticks[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_lfsr[i] == 16'h0) m_lfsr[i] <= SEED;
                else if (en[i]) m_lfsr[i] <= lfsr_step(m_lfsr[i]);
                case (m_phase[i])
                    0: begin
                        m_delay[i] <= cand_of(i, m_lfsr[i]);
                        m_ticks[i] <= 0;
                        if (!sd[i]) m_phase[i] <= 1;
                    end
                    1: begin
                        if (sd[i]) begin
                            m_phase[i] <= 0;
                        end else if (tk[i]) begin
                            m_ticks[i] <= m_ticks[i] + 1;
                            if (m_ticks[i] + 1 == m_delay[i]) m_phase[i] <= 2;
                        end
                    end
                    default: if (sd[i]) m_phase[i] <= 0;
                endcase
            end
        end
    end

    always @(negedge sysclk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check("model_lfsr", i, longint'(lfsr_w[i]), longint'(m_lfsr[i]));
                check("model_delay", i, longint'(dly_w[i]), longint'(m_delay[i]));
                check("model_time_out", i, longint'(to_w[i]), (m_phase[i] == 2) ? 1 : 0);
                check("model_busy", i, longint'(busy_w[i]), (m_phase[i] == 1) ? 1 : 0);
            end
        end
    end

    task automatic tick_b();
        tk[1] = 1'b1;
        @(negedge sysclk);
        tk[1] = 1'b0;
        @(negedge sysclk);
    endtask

    initial begin
        rst_n = 1'b0;
        sd    = 2'b11;
        tk    = 2'b00;
        en    = 2'b00;
        repeat (3) @(negedge sysclk);
        check("rst_lfsr", 0, longint'(lfsr_w[0]), 64'hACE1);
        check("rst_delay", 0, longint'(dly_w[0]), 0);
        check("rst_time_out", 0, longint'(to_w[0]), 0);
        check("rst_busy", 0, longint'(busy_w[0]), 0);
        chk_en = 1'b1;

        rst_n = 1'b1;
        @(negedge sysclk);
        check("hold_delay", 0, longint'(dly_w[0]), 3547);
        check("hold_delay", 1, longint'(dly_w[1]), 4);

        en[0] = 1'b1;
        @(negedge sysclk);
        en[0] = 1'b0;
        check("lfsr_step", 0, longint'(lfsr_w[0]), 64'h59C3);
        @(negedge sysclk);
        check("step_delay", 0, longint'(dly_w[0]), 2749);

        en[0] = 1'b1;
        saw_zero = 1'b0;
        repeat (65535) begin
            @(negedge sysclk);
            if (lfsr_w[0] == 16'h0) saw_zero = 1'b1;
        end
        en[0] = 1'b0;
        check("lfsr_period", 0, longint'(lfsr_w[0]), 64'h59C3);
        check("lfsr_nonzero", 0, longint'(saw_zero), 0);

        // Full countdown on the short-hold instance (delay 4)
        sd[1] = 1'b0;
        @(negedge sysclk);
        check("cnt_busy_start", 1, longint'(busy_w[1]), 1);
        repeat (3) tick_b();
        check("cnt_to_3", 1, longint'(to_w[1]), 0);
        check("cnt_busy_3", 1, longint'(busy_w[1]), 1);
        tick_b();
        check("cnt_to_4", 1, longint'(to_w[1]), 1);
        check("cnt_busy_4", 1, longint'(busy_w[1]), 0);
        repeat (10) tick_b();
        check("done_hold", 1, longint'(to_w[1]), 1);

        // Tick coincident with the arm-to-count transition is ignored
        sd[1] = 1'b1;
        repeat (2) @(negedge sysclk);
        check("rearm_to", 1, longint'(to_w[1]), 0);
        check("rearm_delay", 1, longint'(dly_w[1]), 4);
        sd[1] = 1'b0;
        tk[1] = 1'b1;
        @(negedge sysclk);
        tk[1] = 1'b0;
        check("trans_busy", 1, longint'(busy_w[1]), 1);
        repeat (3) tick_b();
        check("trans_to_3", 1, longint'(to_w[1]), 0);
        tick_b();
        check("trans_to_4", 1, longint'(to_w[1]), 1);

        // Abort with two ticks left, then a full countdown again
        sd[1] = 1'b1;
        repeat (2) @(negedge sysclk);
        sd[1] = 1'b0;
        @(negedge sysclk);
        repeat (2) tick_b();
        sd[1] = 1'b1;
        @(negedge sysclk);
        check("abort_to", 1, longint'(to_w[1]), 0);
        check("abort_busy", 1, longint'(busy_w[1]), 0);
        check("abort_delay", 1, longint'(dly_w[1]), 4);
        sd[1] = 1'b0;
        @(negedge sysclk);
        repeat (3) tick_b();
        check("restart_to_3", 1, longint'(to_w[1]), 0);
        tick_b();
        check("restart_to_4", 1, longint'(to_w[1]), 1);

        // Asynchronous reset between edges while counting
        sd[1] = 1'b1;
        @(negedge sysclk);
        sd[1] = 1'b0;
        @(negedge sysclk);
        tick_b();
        check("pre_rst_busy", 1, longint'(busy_w[1]), 1);
        @(posedge sysclk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_to", 1, longint'(to_w[1]), 0);
        check("arst_busy", 1, longint'(busy_w[1]), 0);
        check("arst_lfsr", 1, longint'(lfsr_w[1]), 64'hACE1);
        sd = 2'b11;
        @(negedge sysclk);
        rst_n = 1'b1;

        // Randomized traffic on both instances, checked by the model every cycle
        repeat (4000) begin
            @(negedge sysclk);
            for (int i = 0; i < 2; i++) begin
                if (sd[i]) sd[i] = ($urandom_range(3) != 0);
                else sd[i] = ($urandom_range(23) == 0);
                tk[i] = ($urandom_range(2) == 0);
                en[i] = ($urandom_range(3) == 0);
            end
        end
        @(negedge sysclk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
